// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder stage, LSB first; done pulses WIDTH edges after start is accepted.
// start is accepted only in IDLE or DONE; it is ignored while busy.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, psum, psum_nxt;
    logic             carry, s, co;
    logic [CW-1:0]    cnt;
    logic             load, last;

    // The single shared full-adder stage.
    always_comb begin
        s        = a_sh[0] ^ b_sh[0] ^ carry;
        co       = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        psum_nxt = psum >> 1;
        psum_nxt[WIDTH-1] = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        last      = (cnt == LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            psum  <= psum_nxt;
            carry <= co;
            cnt   <= cnt + 1'b1;
            // Result registers move only on the final bit, so partial sums never show.
            if (last) begin
                sum  <= psum_nxt;
                cout <= co;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 with a result scoreboard per instance.
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       st8, ci8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       st1, ci1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] held8 = '0;
    logic [1:0] held1 = '0;
    logic [8:0] e8;
    logic [1:0] e1;
    int         done_seen8 = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(ci1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: results popped on done, otherwise outputs must hold the last result.
    always @(negedge clk) begin
        if (rst) begin
            held8 = '0;
            held1 = '0;
        end else begin
            if (done8) begin
                done_seen8++;
                chk("sb8_nonempty", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    e8 = q8.pop_front();
                    chk("sb8_result", 32'({cout8, sum8}), 32'(e8));
                    held8 = e8;
                end
            end else begin
                chk("hold8", 32'({cout8, sum8}), 32'(held8));
            end
            if (done1) begin
                chk("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    chk("sb1_result", 32'({cout1, sum1}), 32'(e1));
                    held1 = e1;
                end
            end else begin
                chk("hold1", 32'({cout1, sum1}), 32'(held1));
            end
        end
    end

    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input bit push);
        a8  = av;
        b8  = bv;
        ci8 = cv;
        st8 = 1'b1;
        if (push) q8.push_back({1'b0, av} + {1'b0, bv} + 9'(cv));
        tick();
        st8 = 1'b0;
    endtask

    task automatic wait_done8(input int exp_lat, input int exp_busy, input string tag);
        int n  = 0;
        int nb = 0;
        while (!done8 && n < 40) begin
            if (busy8) nb++;
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(nb), 32'(exp_busy));
        chk({tag, "_busy_in_done"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        logic [2:0] t;
        int         d0;
        rst = 1'b1;
        st8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        st1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        repeat (2) tick();
        chk("reset8", 32'({busy8, done8, cout8, sum8}), 32'd0);
        chk("reset1", 32'({busy1, done1, cout1, sum1}), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        start8(8'h35, 8'h4A, 1'b0, 1'b1);
        wait_done8(8, 8, "t35");
        tick();
        chk("t35_pulse", 32'(done8), 32'd0);
        repeat (3) tick();
        chk("t35_held", 32'({cout8, sum8}), 32'h07F);

        start8(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done8(8, 8, "tff01");
        tick();
        start8(8'hFF, 8'hFF, 1'b1, 1'b1);
        wait_done8(8, 8, "tffff");
        tick();

        start8(8'h10, 8'h20, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            st8 = (i == 1);
            a8  = 8'hAA ^ {8{i[0]}};
            b8  = 8'h55 ^ {8{i[0]}};
            ci8 = ~ci8;
            tick();
        end
        st8 = 1'b0;
        wait_done8(5, 5, "ign");
        repeat (3) tick();
        chk("ign_no_restart", 32'(busy8), 32'd0);

        start8(8'h80, 8'h80, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("abort_outputs", 32'({busy8, done8, cout8, sum8}), 32'd0);
        tick();
        rst = 1'b0;
        d0 = done_seen8;
        repeat (12) tick();
        chk("abort_no_done", 32'(done_seen8 - d0), 32'd0);
        start8(8'h80, 8'h80, 1'b0, 1'b1);
        wait_done8(8, 8, "t80");
        tick();

        a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; st8 = 1'b1;
        q8.push_back(9'h030);
        tick();
        st8 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("b2b_busy1", 32'(busy8), 32'd1);
            tick();
        end
        a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; st8 = 1'b1;
        q8.push_back(9'h003);
        tick();
        chk("b2b_done1", 32'({done8, busy8}), 32'b10);
        tick();
        st8 = 1'b0;
        chk("b2b_restart", 32'({done8, busy8}), 32'b01);
        wait_done8(8, 8, "b2b2");
        tick();
        chk("b2b_pulse", 32'(done8), 32'd0);

        for (int v = 0; v < 8; v++) begin
            t   = v[2:0];
            a1  = t[2];
            b1  = t[1];
            ci1 = t[0];
            st1 = 1'b1;
            q1.push_back({(t[2] & t[1]) | (t[2] & t[0]) | (t[1] & t[0]), t[2] ^ t[1] ^ t[0]});
            tick();
            st1 = 1'b0;
            chk("w1_busy", 32'({busy1, done1}), 32'b10);
            tick();
            chk("w1_done", 32'({busy1, done1}), 32'b01);
            tick();
            chk("w1_idle", 32'({busy1, done1}), 32'b00);
        end

        tick();
        chk("sb8_drained", 32'(q8.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
